// File: rtl/single_port_lutram_requester_if.sv
// rtl/single_port_lutram_requester_if.sv - request/response channel bundle for the lutram requester
interface single_port_lutram_requester_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
);
  logic              request_valid_in;
  logic              request_ready_out;
  logic              request_write_in;
  logic [ADDR_W-1:0] request_addr_in;
  logic [DATA_W-1:0] request_data_in;
  logic              response_valid_out;
  logic              response_ready_in;
  logic [DATA_W-1:0] response_data_out;
  logic [ADDR_W-1:0] response_addr_out;
  logic              response_is_write_out;

  modport slave (
    input  request_valid_in, request_write_in, request_addr_in, request_data_in,
    input  response_ready_in,
    output request_ready_out,
    output response_valid_out, response_data_out, response_addr_out, response_is_write_out
  );

  modport master (
    output request_valid_in, request_write_in, request_addr_in, request_data_in,
    output response_ready_in,
    input  request_ready_out,
    input  response_valid_out, response_data_out, response_addr_out, response_is_write_out
  );
endinterface

// File: rtl/single_port_lutram_requester.sv
// rtl/single_port_lutram_requester.sv - request-side controller for single_port_lutram (optional LUTRAM_REQUESTER_WRITE_ACK_EN)
module single_port_lutram_requester #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int RESP_FIFO_DEPTH           = 2
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  single_port_lutram_requester_if.slave        bus,
  output logic                                 lutram_access_en_out,
  output logic                                 lutram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]     lutram_set_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_read_entry_in
);
  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_FIFO_DEPTH);

  logic accept, issue, push, pop;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] push_data;

  // One outstanding storage access at most: the cycle after an accept, its result is pushed
  logic                             pend_q, pend_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] pend_addr_q, pend_addr_d;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
  logic                                 pend_write_q, pend_write_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] pend_data_q, pend_data_d;
  logic                                 fifo_wr_q [RESP_FIFO_DEPTH];
`endif

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] fifo_data_q [RESP_FIFO_DEPTH];
  logic [SET_PTR_WIDTH_IN_BITS-1:0]     fifo_addr_q [RESP_FIFO_DEPTH];

  // Handshake, credits from registered state only, and the storage port
  always_comb begin
    bus.request_ready_out  = (count_q + {{PTR_W{1'b0}}, pend_q}) < DEPTH_C;
    accept                 = bus.request_valid_in & bus.request_ready_out;
    lutram_access_en_out   = accept;
    lutram_write_en_out    = accept & bus.request_write_in;
    lutram_set_addr_out    = bus.request_addr_in;
    lutram_write_entry_out = bus.request_data_in;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
    issue     = accept;
    push_data = pend_write_q ? pend_data_q : lutram_read_entry_in;
`else
    issue     = accept & ~bus.request_write_in;
    push_data = lutram_read_entry_in;
`endif
    push = pend_q;
    pop  = bus.response_valid_out & bus.response_ready_in;
  end

  // Next-state for the pending slot and FIFO bookkeeping
  always_comb begin
    pend_d      = issue;
    pend_addr_d = issue ? bus.request_addr_in : pend_addr_q;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
    pend_write_d = issue ? bus.request_write_in : pend_write_q;
    pend_data_d  = issue ? bus.request_data_in  : pend_data_q;
`endif
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Control registers; reset drops any in-flight access without a response
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
      pend_write_q <= 1'b0;
      pend_data_q  <= '0;
`endif
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
      pend_write_q <= pend_write_d;
      pend_data_q  <= pend_data_d;
`endif
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Response FIFO storage, cleared on reset so the head reads as zero
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
        fifo_wr_q[i]   <= 1'b0;
`endif
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_addr_q[wr_ptr_q] <= pend_addr_q;
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
      fifo_wr_q[wr_ptr_q]   <= pend_write_q;
`endif
    end
  end

  // Response channel presents the FIFO head
  always_comb begin
    bus.response_valid_out = (count_q != '0);
    bus.response_data_out  = fifo_data_q[rd_ptr_q];
    bus.response_addr_out  = fifo_addr_q[rd_ptr_q];
`ifdef LUTRAM_REQUESTER_WRITE_ACK_EN
    bus.response_is_write_out = fifo_wr_q[rd_ptr_q];
`else
    bus.response_is_write_out = 1'b0;
`endif
  end
endmodule
